cam_table_ctrl: RTL and testbench

Sequencing and arbitration front-end for a single `cam_bram` instance. It shares the CAM's one compare port and one write port between a lookup requester and an update requester (learn/delete). It also tracks occupancy with a valid bitmap and allocates free slots, or evicts round-robin when the table is full. It sits between the L2 switch forwarding/learning logic and the MAC-address CAM.

---
 rtl/cam_table_ctrl.sv | 147 ++++++++++++++
 tb/tb_cam_table_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cam_table_ctrl.sv
// Arbitration and sequencing front-end for one cam_bram: it shares the compare and write
// ports between lookups and learn/delete updates, and it allocates slots from a valid bitmap.
module cam_table_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 5,
  parameter int CAM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] lookup_data,
  input  logic                  lookup_valid,
  output logic                  lookup_ready,
  input  logic [DATA_WIDTH-1:0] upd_data,
  input  logic                  upd_delete,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  output logic                  rsp_valid,
  output logic                  rsp_is_upd,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_evict,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  input  logic                  cam_write_busy,
  output logic [ADDR_WIDTH:0]   used_count,
  output logic                  full
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = (CAM_LATENCY < 2) ? 1 : $clog2(CAM_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, CMP, WRITE, WAIT, RSP} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        lat_cnt;
  logic                    op_upd, op_del, wait_first;
  logic [DEPTH-1:0]        valid_map;
  logic [ADDR_WIDTH-1:0]   victim_ptr, free_addr;
  logic                    lookup_fire, upd_fire, cmp_done, need_write;

  function automatic logic [ADDR_WIDTH-1:0] lowest_free(input logic [DEPTH-1:0] map);
    lowest_free = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!map[i]) lowest_free = ADDR_WIDTH'(i);
  endfunction

  assign full        = (used_count == (ADDR_WIDTH+1)'(DEPTH));
  assign free_addr   = lowest_free(valid_map);
  assign lookup_fire = lookup_valid && lookup_ready;
  assign upd_fire    = upd_valid && upd_ready;
  assign cmp_done    = (state == CMP) && (lat_cnt == '0);
  // A learn writes only on a miss; a delete writes only on a hit.
  assign need_write  = op_upd && (op_del ? cam_match : !cam_match);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lookup_fire || upd_fire) state_nxt = CMP;
      CMP:     if (lat_cnt == '0) state_nxt = need_write ? WRITE : RSP;
      WRITE:   state_nxt = WAIT;
      WAIT:    if (!wait_first && !cam_write_busy) state_nxt = RSP;
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lookup_ready     = (state == IDLE) && !cam_write_busy && !rst;
    upd_ready        = lookup_ready && !lookup_valid;
    cam_write_enable = (state == WRITE);
    rsp_valid        = (state == RSP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cam_compare_data <= '0;
      op_upd           <= 1'b0;
      op_del           <= 1'b0;
      lat_cnt          <= '0;
      wait_first       <= 1'b0;
      rsp_is_upd       <= 1'b0;
      rsp_hit          <= 1'b0;
      rsp_addr         <= '0;
      rsp_evict        <= 1'b0;
      cam_write_addr   <= '0;
      cam_write_data   <= '0;
      cam_write_delete <= 1'b0;
      valid_map        <= '0;
      victim_ptr       <= '0;
      used_count       <= '0;
    end else begin
      wait_first <= (state == WRITE);
      if (lookup_fire) begin
        cam_compare_data <= lookup_data;
        op_upd           <= 1'b0;
        op_del           <= 1'b0;
        lat_cnt          <= CNT_W'(CAM_LATENCY);
      end else if (upd_fire) begin
        cam_compare_data <= upd_data;
        op_upd           <= 1'b1;
        op_del           <= upd_delete;
        lat_cnt          <= CNT_W'(CAM_LATENCY);
      end else if (state == CMP && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end
      // Compare result is valid: record the response and, for writes, the target slot.
      if (cmp_done) begin
        rsp_is_upd       <= op_upd;
        rsp_hit          <= cam_match;
        rsp_addr         <= cam_match ? cam_match_addr : '0;
        rsp_evict        <= 1'b0;
        cam_write_data   <= cam_compare_data;
        cam_write_delete <= op_del;
        cam_write_addr   <= cam_match_addr;
        if (op_upd && !op_del && !cam_match) begin
          if (full) begin
            cam_write_addr <= victim_ptr;
            rsp_addr       <= victim_ptr;
            rsp_evict      <= 1'b1;
            victim_ptr     <= victim_ptr + ADDR_WIDTH'(1);
          end else begin
            cam_write_addr       <= free_addr;
            rsp_addr             <= free_addr;
            valid_map[free_addr] <= 1'b1;
            used_count           <= used_count + (ADDR_WIDTH+1)'(1);
          end
        end
        if (op_upd && op_del && cam_match) begin
          valid_map[cam_match_addr] <= 1'b0;
          if (valid_map[cam_match_addr] && used_count != '0)
            used_count <= used_count - (ADDR_WIDTH+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_cam_table_ctrl.sv
// Directed bench for cam_table_ctrl with a behavioural 32-entry CAM (latency 2) and a busy model.
module tb_cam_table_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] lookup_data = '0;
  logic        lookup_valid = 1'b0;
  logic        lookup_ready;
  logic [63:0] upd_data = '0;
  logic        upd_delete = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic        rsp_valid, rsp_is_upd, rsp_hit, rsp_evict;
  logic [4:0]  rsp_addr;
  logic [63:0] cam_compare_data;
  logic        cam_match;
  logic [4:0]  cam_match_addr;
  logic [4:0]  cam_write_addr;
  logic [63:0] cam_write_data;
  logic        cam_write_delete, cam_write_enable, cam_write_busy;
  logic [5:0]  used_count;
  logic        full;

  int tests = 0;
  int fails = 0;

  cam_table_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .CAM_LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .lookup_data(lookup_data), .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .upd_data(upd_data), .upd_delete(upd_delete), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .rsp_valid(rsp_valid), .rsp_is_upd(rsp_is_upd), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
    .rsp_evict(rsp_evict), .cam_compare_data(cam_compare_data), .cam_match(cam_match),
    .cam_match_addr(cam_match_addr), .cam_write_addr(cam_write_addr),
    .cam_write_data(cam_write_data), .cam_write_delete(cam_write_delete),
    .cam_write_enable(cam_write_enable), .cam_write_busy(cam_write_busy),
    .used_count(used_count), .full(full)
  );

  always #5 clk = ~clk;

  // Behavioural CAM: registered-key compare, two-stage result pipeline, busy after each write.
  logic [63:0] cam_key [32];
  logic        cam_vld [32];
  logic        cmp_hit, m1_hit, m2_hit;
  logic [4:0]  cmp_addr, m1_addr, m2_addr;
  int          busy_cnt = 0;
  int          busy_len = 2;
  logic        busy_force = 1'b0;

  always_comb begin
    cmp_hit  = 1'b0;
    cmp_addr = '0;
    for (int i = 31; i >= 0; i--)
      if (cam_vld[i] === 1'b1 && cam_key[i] == cam_compare_data) begin
        cmp_hit  = 1'b1;
        cmp_addr = 5'(i);
      end
  end

  always @(posedge clk) begin
    m1_hit <= cmp_hit;  m1_addr <= cmp_addr;
    m2_hit <= m1_hit;   m2_addr <= m1_addr;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin cam_vld[i] <= 1'b0; cam_key[i] <= '0; end
      busy_cnt <= 0;
    end else begin
      if (cam_write_enable) begin
        cam_key[cam_write_addr] <= cam_write_data;
        cam_vld[cam_write_addr] <= !cam_write_delete;
        busy_cnt <= busy_len;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
      end
    end
  end

  assign cam_match      = m2_hit;
  assign cam_match_addr = m2_addr;
  assign cam_write_busy = busy_force || (busy_cnt != 0);

  // Captured observations of the most recent operation
  int          r_n, w_n;
  logic        r_hit, r_evict, r_isupd, w_seen, w_del;
  logic [4:0]  r_addr, w_addr;

  task automatic wait_rsp();
    r_n = 999; w_seen = 0; w_n = 999; w_addr = '0; w_del = 0;
    r_hit = 0; r_evict = 0; r_isupd = 0; r_addr = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (cam_write_enable && !w_seen) begin
        w_seen = 1; w_n = n; w_addr = cam_write_addr; w_del = cam_write_delete;
      end
      if (rsp_valid) begin
        r_n = n; r_hit = rsp_hit; r_addr = rsp_addr; r_evict = rsp_evict; r_isupd = rsp_is_upd;
        break;
      end
    end
  endtask

  task automatic send(input bit is_upd, input logic [63:0] key, input bit del);
    int k;
    @(negedge clk);
    if (is_upd) begin upd_data = key; upd_delete = del; upd_valid = 1; end
    else begin lookup_data = key; lookup_valid = 1; end
    k = 0;
    while (!(is_upd ? upd_ready : lookup_ready) && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    lookup_valid = 0; upd_valid = 0;
    wait_rsp();
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    tests++; if (lookup_ready !== 1'b0 || upd_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_low: got %b%b want 00", lookup_ready, upd_ready); end
    rst = 0; #1;
    tests++; if (lookup_ready !== 1'b1 || upd_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_high: got %b%b want 11", lookup_ready, upd_ready); end
    tests++; if (used_count !== 6'd0 || full !== 1'b0) begin fails++; $display("FAIL reset_count: got %0d full %b want 0 0", used_count, full); end
    tests++; if ({rsp_valid, rsp_is_upd, rsp_hit, rsp_evict, rsp_addr, cam_write_enable, cam_write_delete, cam_write_addr} !== '0 || cam_compare_data !== 64'd0 || cam_write_data !== 64'd0)
      begin fails++; $display("FAIL reset_outputs: got rsp_valid %b we %b cmp %0h want all 0", rsp_valid, cam_write_enable, cam_compare_data); end
  endtask

  task automatic test_learn_lookup();
    send(1, 64'h0000_1122_3344_5566, 0);
    tests++; if (w_seen !== 1'b1 || w_n != 3 || w_addr !== 5'd0 || w_del !== 1'b0) begin fails++; $display("FAIL learn_write: seen %b cyc %0d addr %0d del %b want 1 3 0 0", w_seen, w_n, w_addr, w_del); end
    tests++; if (r_isupd !== 1'b1 || r_hit !== 1'b0 || r_addr !== 5'd0 || r_evict !== 1'b0) begin fails++; $display("FAIL learn_rsp: upd %b hit %b addr %0d ev %b want 1 0 0 0", r_isupd, r_hit, r_addr, r_evict); end
    tests++; if (r_n < 5 || r_n > 12) begin fails++; $display("FAIL learn_latency: got %0d want 5..12", r_n); end
    tests++; if (used_count !== 6'd1) begin fails++; $display("FAIL learn_count: got %0d want 1", used_count); end
    send(0, 64'h0000_1122_3344_5566, 0);
    tests++; if (r_n != 3) begin fails++; $display("FAIL lookup_latency: got %0d want 3", r_n); end
    tests++; if (r_isupd !== 1'b0 || r_hit !== 1'b1 || r_addr !== 5'd0 || w_seen !== 1'b0) begin fails++; $display("FAIL lookup_hit: upd %b hit %b addr %0d wr %b want 0 1 0 0", r_isupd, r_hit, r_addr, w_seen); end
    send(0, 64'h0000_0000_0000_dead, 0);
    tests++; if (r_hit !== 1'b0 || r_addr !== 5'd0 || r_n != 3) begin fails++; $display("FAIL lookup_miss: hit %b addr %0d cyc %0d want 0 0 3", r_hit, r_addr, r_n); end
  endtask

  task automatic test_dup_learn();
    send(1, 64'h0000_1122_3344_5566, 0);
    tests++; if (w_seen !== 1'b0) begin fails++; $display("FAIL dup_no_write: got write %b want 0", w_seen); end
    tests++; if (r_hit !== 1'b1 || r_addr !== 5'd0 || r_n != 3) begin fails++; $display("FAIL dup_rsp: hit %b addr %0d cyc %0d want 1 0 3", r_hit, r_addr, r_n); end
    tests++; if (used_count !== 6'd1) begin fails++; $display("FAIL dup_count: got %0d want 1", used_count); end
  endtask

  task automatic test_fill_evict();
    for (int i = 1; i < 32; i++) begin
      send(1, 64'h1000 + 64'(i), 0);
      tests++; if (w_seen !== 1'b1 || w_addr !== 5'(i) || r_addr !== 5'(i) || r_evict !== 1'b0) begin fails++; $display("FAIL fill_addr[%0d]: wr %b addr %0d rsp %0d ev %b", i, w_seen, w_addr, r_addr, r_evict); end
    end
    tests++; if (full !== 1'b1 || used_count !== 6'd32) begin fails++; $display("FAIL fill_full: full %b count %0d want 1 32", full, used_count); end
    send(1, 64'h2000, 0);
    tests++; if (w_seen !== 1'b1 || w_addr !== 5'd0 || r_evict !== 1'b1 || r_addr !== 5'd0 || r_hit !== 1'b0) begin fails++; $display("FAIL evict0: wr %b addr %0d ev %b rsp %0d", w_seen, w_addr, r_evict, r_addr); end
    tests++; if (used_count !== 6'd32) begin fails++; $display("FAIL evict_count: got %0d want 32", used_count); end
    send(1, 64'h2001, 0);
    tests++; if (w_addr !== 5'd1 || r_evict !== 1'b1) begin fails++; $display("FAIL evict1: addr %0d ev %b want 1 1", w_addr, r_evict); end
    send(0, 64'h0000_1122_3344_5566, 0);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL evicted_gone: hit %b want 0", r_hit); end
  endtask

  task automatic test_delete_reuse();
    send(1, 64'h1005, 1);
    tests++; if (w_seen !== 1'b1 || w_del !== 1'b1 || w_addr !== 5'd5 || w_n != 3) begin fails++; $display("FAIL del_write: wr %b del %b addr %0d cyc %0d want 1 1 5 3", w_seen, w_del, w_addr, w_n); end
    tests++; if (r_hit !== 1'b1 || r_addr !== 5'd5 || used_count !== 6'd31 || full !== 1'b0) begin fails++; $display("FAIL del_rsp: hit %b addr %0d count %0d full %b", r_hit, r_addr, used_count, full); end
    send(1, 64'hbeef, 1);
    tests++; if (w_seen !== 1'b0 || r_hit !== 1'b0 || r_addr !== 5'd0 || r_n != 3 || used_count !== 6'd31) begin fails++; $display("FAIL del_miss: wr %b hit %b addr %0d cyc %0d count %0d", w_seen, r_hit, r_addr, r_n, used_count); end
    send(1, 64'h3000, 0);
    tests++; if (w_addr !== 5'd5 || r_evict !== 1'b0 || used_count !== 6'd32) begin fails++; $display("FAIL reuse: addr %0d ev %b count %0d want 5 0 32", w_addr, r_evict, used_count); end
    send(0, 64'h1005, 0);
    tests++; if (r_hit !== 1'b0) begin fails++; $display("FAIL deleted_lookup: hit %b want 0", r_hit); end
  endtask

  task automatic test_arbitration();
    int k;
    @(negedge clk);
    lookup_data = 64'h1010; lookup_valid = 1;
    upd_data = 64'h4000; upd_delete = 0; upd_valid = 1;
    #1;
    tests++; if (lookup_ready !== 1'b1 || upd_ready !== 1'b0) begin fails++; $display("FAIL arb_ready: lk %b up %b want 1 0", lookup_ready, upd_ready); end
    @(posedge clk); #1;
    lookup_valid = 0;
    wait_rsp();
    tests++; if (r_isupd !== 1'b0 || r_hit !== 1'b1 || r_addr !== 5'd16 || r_n != 3) begin fails++; $display("FAIL arb_first: upd %b hit %b addr %0d cyc %0d want 0 1 16 3", r_isupd, r_hit, r_addr, r_n); end
    k = 0;
    while (!upd_ready && k < 50) begin @(negedge clk); k++; end
    tests++; if (k != 1) begin fails++; $display("FAIL arb_upd_wait: got %0d cycles want 1", k); end
    @(posedge clk); #1;
    upd_valid = 0;
    wait_rsp();
    tests++; if (r_isupd !== 1'b1 || r_evict !== 1'b1 || w_addr !== 5'd2 || r_hit !== 1'b0) begin fails++; $display("FAIL arb_second: upd %b ev %b addr %0d hit %b want 1 1 2 0", r_isupd, r_evict, w_addr, r_hit); end
  endtask

  task automatic test_busy_guard();
    int blocked;
    @(negedge clk);
    busy_force = 1;
    lookup_data = 64'h1010; lookup_valid = 1;
    blocked = 0;
    repeat (4) begin
      @(negedge clk);
      if (lookup_ready === 1'b0 && rsp_valid === 1'b0) blocked++;
    end
    tests++; if (blocked != 4 || cam_compare_data !== 64'h4000) begin fails++; $display("FAIL busy_block: blocked %0d cmp %0h want 4 4000", blocked, cam_compare_data); end
    busy_force = 0; #1;
    tests++; if (lookup_ready !== 1'b1) begin fails++; $display("FAIL busy_release: ready %b want 1", lookup_ready); end
    @(posedge clk); #1;
    lookup_valid = 0;
    wait_rsp();
    tests++; if (r_hit !== 1'b1 || r_addr !== 5'd16 || r_n != 3) begin fails++; $display("FAIL busy_lookup: hit %b addr %0d cyc %0d want 1 16 3", r_hit, r_addr, r_n); end
  endtask

  initial begin
    test_reset();
    test_learn_lookup();
    test_dup_learn();
    test_fill_evict();
    test_delete_reuse();
    test_arbitration();
    test_busy_guard();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
